// File: rtl/param_binary_search_pkg.sv
// Shared types and width helpers for the parametrised binary-search engine.
package param_binary_search_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_PROBE   = 3'd1;
   localparam state_t ST_WAIT    = 3'd2;
   localparam state_t ST_COMPARE = 3'd3;
   localparam state_t ST_DONE    = 3'd4;

   // Probe counter must hold up to ADDR_W+1 reads.
   function automatic int probe_cnt_w(input int addr_w);
      return $clog2(addr_w + 3);
   endfunction

   function automatic int wait_cnt_w(input int rd_lat);
      return (rd_lat > 1) ? $clog2(rd_lat) : 1;
   endfunction

endpackage

// File: rtl/param_binary_search_if.sv
// Control/result and RAM-read bundle for param_binary_search.
interface param_binary_search_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) ();
   import param_binary_search_pkg::*;

   localparam int PW = probe_cnt_w(ADDR_W);

   // Handshake: start is a level request sampled only in IDLE; busy covers the
   // search, done stays high until start is dropped, results hold until the next accept.
   logic              start;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic              busy;
   logic              done;
   logic              found;
   logic [ADDR_W:0]   index;
   logic [PW-1:0]     probes;
   state_t            state_dbg;

   modport master (
      output start, A, ram_rdata,
      input  ram_addr, busy, done, found, index, probes, state_dbg
   );

   modport slave (
      input  start, A, ram_rdata,
      output ram_addr, busy, done, found, index, probes, state_dbg
   );

endinterface

// File: rtl/param_binary_search_dp.sv
// Datapath: half-open [lo,hi) interval, target latch, comparator, result
// registers and the RAM read-latency counter, all driven by FSM strobes.
module param_binary_search_dp
   import param_binary_search_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1,
   localparam int PW    = probe_cnt_w(ADDR_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic              load_addr,
   input  logic              wait_en,
   input  logic              step_lo,
   input  logic              step_hi,
   input  logic              set_found,
   input  logic              latch_index,
   input  logic              index_from_mid,
   input  logic [DATA_W-1:0] target_in,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              found,
   output logic [ADDR_W:0]   index,
   output logic [PW-1:0]     probes,
   output logic              wait_done,
   output logic              cmp_lt,
   output logic              cmp_eq,
   output logic              more
);

   localparam int            WCW     = wait_cnt_w(RD_LAT);
   localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0]   lo_q, lo_d;
   logic [ADDR_W:0]   hi_q, hi_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              found_q, found_d;
   logic [ADDR_W:0]   index_q, index_d;
   logic [PW-1:0]     probes_q, probes_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;

   logic [ADDR_W:0]   sum;
   logic [ADDR_W:0]   mid;
   logic [ADDR_W:0]   mid_p1;
   logic [ADDR_W:0]   lo_cmp;
   logic [ADDR_W:0]   hi_cmp;

   // lo+hi <= 2*DEPTH-1 while lo < hi, so ADDR_W+1 bits cannot overflow.
   assign sum    = lo_q + hi_q;
   assign mid    = sum >> 1;
   assign mid_p1 = mid + (ADDR_W + 1)'(1);

   assign cmp_lt    = ram_rdata < target_q;
   assign cmp_eq    = ram_rdata == target_q;
   assign lo_cmp    = cmp_lt ? mid_p1 : lo_q;
   assign hi_cmp    = cmp_lt ? hi_q : mid;
   assign more      = lo_cmp < hi_cmp;
   assign wait_done = (wcnt_q == WCW'(RD_LAT - 1));

   always_comb begin
      lo_d     = lo_q;
      hi_d     = hi_q;
      target_d = target_q;
      addr_d   = addr_q;
      found_d  = found_q;
      index_d  = index_q;
      probes_d = probes_q;
      wcnt_d   = wcnt_q;
      if (init) begin
         lo_d     = '0;
         hi_d     = DEPTH_V;
         target_d = target_in;
         found_d  = 1'b0;
         probes_d = '0;
      end
      if (load_addr) begin
         addr_d   = mid[ADDR_W-1:0];
         probes_d = probes_q + PW'(1);
         wcnt_d   = '0;
      end
      if (wait_en && !wait_done) begin
         wcnt_d = wcnt_q + WCW'(1);
      end
      if (step_lo) begin
         lo_d = mid_p1;
      end
      if (step_hi) begin
         hi_d = mid;
      end
      if (set_found) begin
         found_d = 1'b1;
      end
      // At loop exit lo_cmp == hi_cmp, which is the lower-bound position.
      if (latch_index) begin
         index_d = index_from_mid ? mid : lo_cmp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_q     <= '0;
         hi_q     <= DEPTH_V;
         target_q <= '0;
         addr_q   <= '0;
         found_q  <= 1'b0;
         index_q  <= '0;
         probes_q <= '0;
         wcnt_q   <= '0;
      end else begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         target_q <= target_d;
         addr_q   <= addr_d;
         found_q  <= found_d;
         index_q  <= index_d;
         probes_q <= probes_d;
         wcnt_q   <= wcnt_d;
      end
   end

   assign ram_addr = addr_q;
   assign found    = found_q;
   assign index    = index_q;
   assign probes   = probes_q;

   a_lo_le_hi: assert property (@(posedge clk) disable iff (reset) lo_q <= hi_q);
   a_mid_range: assert property (@(posedge clk) disable iff (reset) load_addr |-> (mid < DEPTH_V));

endmodule

// File: rtl/param_binary_search.sv
// Binary search over an external ascending-sorted synchronous RAM; returns the
// lower-bound index (or any match with EARLY_EXIT) plus found and probe count.
module param_binary_search
   import param_binary_search_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter int RD_LAT     = 1,
   parameter int EARLY_EXIT = 0
) (
   input  logic               clk,
   input  logic               reset,
   param_binary_search_if.slave bus
);

   localparam int PW = probe_cnt_w(ADDR_W);

   state_t state_q, state_d;

   logic              init;
   logic              load_addr;
   logic              wait_en;
   logic              step_lo;
   logic              step_hi;
   logic              set_found;
   logic              latch_index;
   logic              index_from_mid;
   logic              wait_done;
   logic              cmp_lt;
   logic              cmp_eq;
   logic              more;
   logic [ADDR_W-1:0] ram_addr;
   logic              found;
   logic [ADDR_W:0]   index;
   logic [PW-1:0]     probes;
   logic              busy;
   logic              done;

   always_comb begin
      state_d        = state_q;
      init           = 1'b0;
      load_addr      = 1'b0;
      wait_en        = 1'b0;
      step_lo        = 1'b0;
      step_hi        = 1'b0;
      set_found      = 1'b0;
      latch_index    = 1'b0;
      index_from_mid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               init    = 1'b1;
               state_d = ST_PROBE;
            end
         end
         ST_PROBE: begin
            load_addr = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            wait_en = 1'b1;
            if (wait_done) begin
               state_d = ST_COMPARE;
            end
         end
         ST_COMPARE: begin
            step_lo   = cmp_lt;
            step_hi   = !cmp_lt;
            set_found = cmp_eq;
            if (cmp_eq && (EARLY_EXIT != 0)) begin
               latch_index    = 1'b1;
               index_from_mid = 1'b1;
               state_d        = ST_DONE;
            end else if (more) begin
               state_d = ST_PROBE;
            end else begin
               latch_index = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!bus.start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Decoded from the state flop so reset clears them without waiting for an edge.
   assign busy = (state_q == ST_PROBE) || (state_q == ST_WAIT) || (state_q == ST_COMPARE);
   assign done = (state_q == ST_DONE);

   param_binary_search_dp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_dp (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .load_addr      (load_addr),
      .wait_en        (wait_en),
      .step_lo        (step_lo),
      .step_hi        (step_hi),
      .set_found      (set_found),
      .latch_index    (latch_index),
      .index_from_mid (index_from_mid),
      .target_in      (bus.A),
      .ram_rdata      (bus.ram_rdata),
      .ram_addr       (ram_addr),
      .found          (found),
      .index          (index),
      .probes         (probes),
      .wait_done      (wait_done),
      .cmp_lt         (cmp_lt),
      .cmp_eq         (cmp_eq),
      .more           (more)
   );

   assign bus.ram_addr  = ram_addr;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.found     = found;
   assign bus.index     = index;
   assign bus.probes    = probes;
   assign bus.state_dbg = state_q;

   a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));

endmodule

// File: tb/tb_param_binary_search.sv
// Bench for param_binary_search: three configurations (lower bound, early exit,
// ADDR_W=3/RD_LAT=2) against behavioural synchronous RAMs.
module tb_param_binary_search;
   import param_binary_search_pkg::*;

   typedef struct packed {
      logic       found;
      logic [6:0] index;
      logic [7:0] probes;
      logic [15:0] cyc;
   } exp_t;

   typedef struct {
      int d;
      int a;
      int found;
      int index;
      int probes;
      int cyc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   exp_t exp_q[$];
   vec_t vq[$];

   logic [7:0] mem0 [32];
   logic [7:0] mem2 [8];
   logic [7:0] pipe2;

   param_binary_search_if #(.DATA_W(8), .ADDR_W(5)) if0 ();
   param_binary_search_if #(.DATA_W(8), .ADDR_W(5)) if1 ();
   param_binary_search_if #(.DATA_W(8), .ADDR_W(3)) if2 ();

   param_binary_search #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .EARLY_EXIT(0)) u_dut0 (
      .clk(clk), .reset(rst), .bus(if0));
   param_binary_search #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .EARLY_EXIT(1)) u_dut1 (
      .clk(clk), .reset(rst), .bus(if1));
   param_binary_search #(.DATA_W(8), .ADDR_W(3), .RD_LAT(2), .EARLY_EXIT(0)) u_dut2 (
      .clk(clk), .reset(rst), .bus(if2));

   // clock / RAM models
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if0.ram_rdata <= mem0[if0.ram_addr];
      if1.ram_rdata <= mem0[if1.ram_addr];
      pipe2         <= mem2[if2.ram_addr];
      if2.ram_rdata <= pipe2;
   end

   // driver / sampling helpers
   task automatic drive(input int d, input logic s, input logic [7:0] a);
      case (d)
         0: begin if0.start = s; if0.A = a; end
         1: begin if1.start = s; if1.A = a; end
         default: begin if2.start = s; if2.A = a; end
      endcase
   endtask

   task automatic snap(input int d, output int dn, output int by, output int fd,
                       output int ix, output int pr, output int ad, output int st);
      case (d)
         0: begin
            dn = int'(if0.done); by = int'(if0.busy); fd = int'(if0.found);
            ix = int'(if0.index); pr = int'(if0.probes); ad = int'(if0.ram_addr);
            st = int'(if0.state_dbg);
         end
         1: begin
            dn = int'(if1.done); by = int'(if1.busy); fd = int'(if1.found);
            ix = int'(if1.index); pr = int'(if1.probes); ad = int'(if1.ram_addr);
            st = int'(if1.state_dbg);
         end
         default: begin
            dn = int'(if2.done); by = int'(if2.busy); fd = int'(if2.found);
            ix = int'(if2.index); pr = int'(if2.probes); ad = int'(if2.ram_addr);
            st = int'(if2.state_dbg);
         end
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(input int f, input int ix, input int pr, input int cy);
      exp_t e;
      e.found  = f[0];
      e.index  = 7'(ix);
      e.probes = (pr < 0) ? 8'hFF : 8'(pr);
      e.cyc    = (cy < 0) ? 16'hFFFF : 16'(cy);
      return e;
   endfunction

   // Reference: first position whose value >= a (linear scan).
   function automatic int lb0(input int a);
      for (int i = 0; i < 32; i++) begin
         if (int'(mem0[i]) >= a) return i;
      end
      return 32;
   endfunction

   task automatic run_search(input int d, input int a, input exp_t e,
                             input bit perturb, input bit keep);
      int   n, dn, by, fd, ix, pr, ad, st;
      exp_t w;
      exp_q.push_back(e);
      drive(d, 1'b1, 8'(a));
      @(posedge clk); #1;
      snap(d, dn, by, fd, ix, pr, ad, st);
      check("busy_on_accept", by, 1);
      check("probes_cleared", pr, 0);
      n = 0;
      while (dn == 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (perturb && n == 2) drive(d, 1'b1, ~8'(a));
         snap(d, dn, by, fd, ix, pr, ad, st);
      end
      w = exp_q.pop_front();
      check("done_seen", dn, 1);
      check("busy_low_in_done", by, 0);
      check("found", fd, int'(w.found));
      check("index", ix, int'(w.index));
      if (w.probes != 8'hFF) check("probes", pr, int'(w.probes));
      else check("probes_bound", int'(pr <= 6), 1);
      if (w.cyc != 16'hFFFF) check("done_cycle", n + 1, int'(w.cyc));
      if (!keep) begin
         drive(d, 1'b0, 8'(a));
         @(posedge clk); #1;
         snap(d, dn, by, fd, ix, pr, ad, st);
         check("done_drop", dn, 0);
         check("found_held", fd, int'(w.found));
         check("index_held", ix, int'(w.index));
      end
   endtask

   task automatic add_vec(input int d, input int a, input int f, input int ix,
                          input int pr, input int cy);
      vec_t v;
      v.d = d; v.a = a; v.found = f; v.index = ix; v.probes = pr; v.cyc = cy;
      vq.push_back(v);
   endtask

   task automatic load_odd();
      for (int i = 0; i < 32; i++) mem0[i] = 8'(2 * i + 1);
   endtask

   initial begin
      int dn, by, fd, ix, pr, ad, st;
      int a, idx, f;

      for (int i = 0; i < 8; i++) mem2[i] = 8'(10 * i);
      load_odd();
      drive(0, 1'b0, 8'd0);
      drive(1, 1'b0, 8'd0);
      drive(2, 1'b0, 8'd0);

      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      snap(0, dn, by, fd, ix, pr, ad, st);
      check("rst_done", dn, 0);
      check("rst_busy", by, 0);
      check("rst_found", fd, 0);
      check("rst_index", ix, 0);
      check("rst_probes", pr, 0);
      check("rst_addr", ad, 0);
      check("rst_state", st, int'(ST_IDLE));
      rst = 1'b0;

      // vector table: {dut, A, found, index, probes, done cycle}
      add_vec(0, 41, 1, 20, 5, 16);
      add_vec(0,  0, 0,  0, 6, 19);
      add_vec(0, 64, 0, 32, 5, 16);
      add_vec(0, 42, 0, 21, 5, 16);
      add_vec(0,  1, 1,  0, 6, 19);
      add_vec(0, 63, 1, 31, 5, 16);
      add_vec(1, 41, 1, 20, 3, 10);
      add_vec(1,  1, 1,  0, 6, 19);
      add_vec(1, 64, 0, 32, 5, 16);
      add_vec(2, 30, 1,  3, 3, 13);
      add_vec(2, 80, 0,  8, 3, 13);
      add_vec(2,  0, 1,  0, 4, 17);
      add_vec(2,  5, 0,  1, 4, 17);

      foreach (vq[i]) begin
         run_search(vq[i].d, vq[i].a,
                    mk_exp(vq[i].found, vq[i].index, vq[i].probes, vq[i].cyc), 1'b0, 1'b0);
      end

      // random targets on the lower-bound instance
      for (int k = 0; k < 8; k++) begin
         a   = int'($urandom_range(0, 70));
         idx = lb0(a);
         f   = (idx < 32 && int'(mem0[idx]) == a) ? 1 : 0;
         run_search(0, a, mk_exp(f, idx, -1, -1), 1'b0, 1'b0);
      end

      // target changed while busy must not disturb the result
      run_search(2, 30, mk_exp(1, 3, 3, 13), 1'b1, 1'b0);

      // duplicates, then hold start high in DONE
      for (int i = 0; i < 32; i++) mem0[i] = (i < 5) ? 8'(i) : (i < 10) ? 8'd7 : 8'(2 * i);
      run_search(0, 7, mk_exp(1, 5, 5, 16), 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         snap(0, dn, by, fd, ix, pr, ad, st);
         check("hold_done", dn, 1);
         check("hold_index", ix, 5);
         check("hold_probes", pr, 5);
      end
      drive(0, 1'b0, 8'd7);
      @(posedge clk); #1;
      snap(0, dn, by, fd, ix, pr, ad, st);
      check("dup_release_done", dn, 0);
      check("dup_release_found", fd, 1);
      check("dup_release_index", ix, 5);
      run_search(0, 20, mk_exp(1, 10, 5, 16), 1'b0, 1'b0);

      // asynchronous reset during the WAIT of the second probe
      load_odd();
      drive(0, 1'b1, 8'd41);
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #3;
      snap(0, dn, by, fd, ix, pr, ad, st);
      check("pre_reset_state", st, int'(ST_WAIT));
      check("pre_reset_probes", pr, 2);
      rst = 1'b1;
      #1;
      snap(0, dn, by, fd, ix, pr, ad, st);
      check("arst_done", dn, 0);
      check("arst_busy", by, 0);
      check("arst_found", fd, 0);
      check("arst_index", ix, 0);
      check("arst_probes", pr, 0);
      check("arst_addr", ad, 0);
      check("arst_state", st, int'(ST_IDLE));
      drive(0, 1'b0, 8'd41);
      @(posedge clk); #1;
      rst = 1'b0;
      run_search(0, 41, mk_exp(1, 20, 5, 16), 1'b0, 1'b0);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_binary_search.md
Name: param_binary_search

Overview:
- Parametrised successor to the 32x8 binary-search engine. Searches an externally owned, ascending-sorted synchronous RAM of depth 2^ADDR_W for a target value.
- Returns one of two results, chosen by mode:
  - the leftmost matching index (lower-bound semantics, duplicate-safe), or
  - any matching index with early exit.
- Always returns the insertion point when the target is absent.
- Sits between board-level controls (switches/keys) and a RAM instance. Configurable data width, depth and RAM read latency.

Parameters:
- DATA_W, 8, width of RAM words and target.
- ADDR_W, 5, RAM address width; DEPTH = 2^ADDR_W; must be >= 1.
- RD_LAT, 1, cycles from ram_addr register update to valid ram_rdata; must be >= 1.
- EARLY_EXIT, 0, 0 = leftmost match / lower bound; 1 = stop on first equal probe.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level request; a new search needs start low then high
- A  in  DATA_W  target value; latched when a search starts
- ram_rdata  in  DATA_W  RAM read data
- ram_addr  out  ADDR_W  registered RAM read address
- busy  out  1  high from acceptance until result is ready
- done  out  1  high while in DONE
- found  out  1  target present
- index  out  ADDR_W+1  match index, or insertion point 0..DEPTH
- probes  out  $clog2(ADDR_W+3)  number of RAM reads used by last search

Behaviour:
- Reset: one clock (clk); asynchronous, active-high reset. Reset asserted at any time, including mid-search, forces:
  - state IDLE
  - ram_addr=0, busy=0, done=0, found=0, index=0, probes=0
  - lo=0, hi=DEPTH, latched target cleared
- Internal registers: lo and hi are ADDR_W+1 bits; interval is half-open [lo, hi). No underflow is possible.
- mid = (lo+hi)>>1, computed at ADDR_W+1 bits; always < DEPTH while lo < hi.
- FSM states: IDLE, PROBE, WAIT, COMPARE, DONE.
  - IDLE: on start=1 at an edge, load lo=0, hi=DEPTH, latch A, found=0, probes=0, busy=1 -> PROBE. Otherwise stay in IDLE; outputs hold their last result.
  - PROBE (1 cycle): ram_addr <= mid[ADDR_W-1:0]; probes++ -> WAIT.
  - WAIT: a counter runs RD_LAT cycles, then -> COMPARE.
  - COMPARE (1 cycle): sample ram_rdata; unsigned compare against the latched target.
    - rdata < target: lo <= mid+1.
    - rdata >= target: hi <= mid; if equal, found <= 1.
    - If equal and EARLY_EXIT=1: index <= mid -> DONE.
    - Else if updated lo < updated hi -> PROBE.
    - Else index <= updated lo -> DONE.
  - DONE: done=1, busy=0. Stays in DONE while start=1; start=0 -> IDLE (done drops; found/index/probes held).
- Timing:
  - Each probe takes 2+RD_LAT cycles.
  - With start sampled at edge 0, done first goes high in cycle 1 + P*(2+RD_LAT), where P = probes.
  - P <= ADDR_W+1.
- Lower-bound mode (EARLY_EXIT=0): index = first position whose value >= target. found=1 iff that value equals the target; no extra read is needed.
- Target above all entries: found=0, index=DEPTH. Target below all entries: found=0, index=0.
- Changes on A or start during busy are ignored. ram_addr holds its value outside PROBE.
- Assertions: lo <= hi at all times; mid < DEPTH in PROBE; done and busy never both high.

Decomposition:
- Package param_binary_search_pkg holds:
  - the state enum typedef (IDLE, PROBE, WAIT, COMPARE, DONE)
  - a localparam helper for the probe counter width
- Sub-module param_binary_search_dp holds the datapath: lo/hi/mid registers, target latch, comparator, index/found/probes registers, and the RD_LAT wait counter.
- The FSM stays in the top module and drives the datapath through control strobes: init, load_addr, step_lo, step_hi, set_found, latch_index.

Test Plan:
- Defaults; RAM mem[i]=2i+1 (1..63); A=41; RD_LAT=1 -> found=1, index=20, probes=5, done high in cycle 16 after the start edge.
- Same RAM, EARLY_EXIT=1, A=41 -> found=1, index=20, probes=3, done in cycle 10.
- A=0 -> found=0, index=0, probes=6. A=64 -> found=0, index=32. A=42 -> found=0, index=21.
- Duplicates: mem[5..9]=7, A=7, EARLY_EXIT=0 -> found=1, index=5. Hold start=1 for 10 extra cycles -> stays in DONE with outputs stable; start=0 then 1 starts a new search.
- RD_LAT=2, ADDR_W=3, mem[i]=10i, A=30 -> found=1, index=3, done in cycle 1+P*4. Vary A mid-search -> result unchanged.
- Assert reset asynchronously during WAIT of the 2nd probe -> all outputs 0 immediately (before the next edge). After release and a start, a full search completes correctly.
